// File: rtl/master_to_blocking_buffer_pkg.sv
// Shared types and constants for the master-to-blocking buffer slice.
// Latency: none, declarations only.
// Backpressure: not applicable.
package scam_model_types;
  // 32-bit integer sample carried between model stages.
  typedef logic [31:0] sc_int_t;
endpackage

package master_to_blocking_buffer_types;
  import scam_model_types::*;

  typedef sc_int_t sample_t;

  localparam int DROP_CNT_W    = 16;
  localparam int DEFAULT_DEPTH = 4;

  // The drop counter sticks here instead of wrapping back to zero.
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

  // Saturating increment for the drop counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
  endfunction
endpackage

// File: rtl/master_to_blocking_buffer_int_fifo.sv
// Circular DEPTH x 32 integer FIFO with occupancy counter and full/empty flags.
// Latency: a push in cycle N is readable on rd_dat_o in cycle N+1; no bypass.
// Backpressure: none internally; caller must only push when !full or popping.
module int_fifo
  import master_to_blocking_buffer_types::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  sample_t       wr_dat_i,
  output sample_t       rd_dat_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  sample_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q,  level_d;

  // Next pointers and occupancy; push+pop together leaves level unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage and pointer registers; reset clears every entry so the head reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= wr_dat_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rd_dat_o = mem_q[rd_ptr_q];
  assign level_o  = level_q;
  assign full_o   = (level_q == LW'(DEPTH));
  assign empty_o  = (level_q == '0);

endmodule

// File: rtl/master_to_blocking_buffer.sv
// Re-presents a non-blocking master stream as a blocking sync/notify port via a small FIFO.
// Latency: 1 cycle from m_in to b_out when empty; otherwise queued behind older entries.
// Backpressure: none toward the master; samples arriving while full (and not popping) are dropped and counted.
module master_to_blocking_buffer
  import master_to_blocking_buffer_types::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           m_in,
  input  logic                  m_in_notify,
  output logic [31:0]           b_out,
  output logic                  b_out_notify,
  input  logic                  b_out_sync,
  output logic [LW-1:0]         level,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  drop_notify
);

  logic                  full, empty;
  logic                  push, pop, drop;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  drop_notify_q, drop_notify_d;

  // Handshake: a full FIFO still accepts a sample in a cycle where the head leaves.
  always_comb begin
    pop           = b_out_notify && b_out_sync;
    push          = m_in_notify && (!full || pop);
    drop          = m_in_notify && full && !pop;
    drop_cnt_d    = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    drop_notify_d = drop;
  end

  // Drop counter and its registered one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q    <= '0;
      drop_notify_q <= 1'b0;
    end else begin
      drop_cnt_q    <= drop_cnt_d;
      drop_notify_q <= drop_notify_d;
    end
  end

  int_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .pop_i    (pop),
    .wr_dat_i (m_in),
    .rd_dat_o (b_out),
    .level_o  (level),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign b_out_notify = !empty;
  assign drop_cnt     = drop_cnt_q;
  assign drop_notify  = drop_notify_q;

endmodule
